// File: rtl/demux_stream_1_n_pkg.sv
// Purpose: shared types, constants and helpers for the 1-to-N stream demux and its mux counterpart.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_stream_1_n_pkg;

    // Defaults shared with the mux counterpart so both ends agree on bus geometry.
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_NUM_OUT = 8;
    localparam int MAX_NUM_OUT = 32;

    // Channel index wide enough for the largest legal channel count.
    typedef logic [$clog2(MAX_NUM_OUT)-1:0] ch_idx_t;

    // Per-channel holding register state.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Low bit of channel k inside a flattened NUM_OUT*width data bus.
    function automatic int slice_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/demux_stream_1_n_if.sv
// Purpose: valid/ready bundle for the 1-to-N demux (one input stream, NUM_OUT output streams).
// Latency: n/a (wiring only).
// Backpressure: in_ready from the demux, per-channel out_ready from consumers.
interface demux_stream_1_n_if #(
    parameter int WIDTH   = demux_stream_1_n_pkg::DEF_WIDTH,
    parameter int NUM_OUT = demux_stream_1_n_pkg::DEF_NUM_OUT,
    parameter int SEL_W   = $clog2(NUM_OUT)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_bcast;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;

    // Environment side: producer plus the per-channel consumers.
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Demux side.
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_stream_1_n_slot.sv
// Purpose: one output channel's holding register (EMPTY/FULL), data forced to zero while empty.
// Latency: 1 cycle load -> out_valid.
// Backpressure: holds word stable while out_ready low; free when empty or draining this cycle.
// Ports: clk, rst_n, load/load_data (from demux), out_ready (consumer), out_valid/out_data, free.
module demux_stream_slot
    import demux_stream_1_n_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);
    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                    data_d  = load_data;
                end
            end
            SLOT_FULL: begin
                // A load while draining replaces the word: full throughput per channel.
                if (load) begin
                    data_d = load_data;
                end else if (out_ready) begin
                    state_d = SLOT_EMPTY;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
                data_d  = '0;
            end
        endcase
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;
    assign free      = (state_q == SLOT_EMPTY) || out_ready;

endmodule

// File: rtl/demux_stream_1_n.sv
// Purpose: registered 1-to-NUM_OUT stream demux with broadcast and saturating bad-select counter.
// Latency: 1 cycle accept -> out_valid.
// Backpressure: in_ready = free[in_sel] (unicast), AND of all free (broadcast), 1 for bad select.
// Ports: clk, rst_n, bus (slave modport of demux_stream_1_n_if), err_cnt, err_clr.
module demux_stream_1_n
    import demux_stream_1_n_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int SEL_W   = $clog2(NUM_OUT),
    parameter int ERR_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_stream_1_n_if.slave   bus,
    output logic [ERR_W-1:0]    err_cnt,
    input  logic                err_clr
);
    localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

    logic [NUM_OUT-1:0] free;
    logic [NUM_OUT-1:0] load;
    logic               sel_ok;
    logic               free_sel;
    logic               accept;
    logic               bad_accept;

    // Extra top bit lets non-power-of-2 channel counts reject the unused codes.
    assign sel_ok = ({1'b0, bus.in_sel} < NUM_OUT_W);

    // Looked up by comparison rather than indexing so an out-of-range select never reads past free[].
    always_comb begin
        free_sel = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                free_sel = free[k];
            end
        end
    end

    // Bad selects are always accepted so a misaddressed producer cannot wedge the input.
    assign bus.in_ready = bus.in_bcast ? (&free) : (sel_ok ? free_sel : 1'b1);
    assign accept       = bus.in_valid && bus.in_ready;
    assign bad_accept   = accept && !bus.in_bcast && !sel_ok;

    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            load[k] = accept && (bus.in_bcast || (sel_ok && (bus.in_sel == SEL_W'(k))));
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_stream_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (bus.in_data),
            .out_ready (bus.out_ready[k]),
            .out_valid (bus.out_valid[k]),
            .out_data  (bus.out_data[slice_lo(k, WIDTH) +: WIDTH]),
            .free      (free[k])
        );
    end

    // Clear wins over a same-cycle increment; count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (bad_accept && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_stream_1_n.sv
// Purpose: directed self-checking bench for demux_stream_1_n (8-channel main, 6-channel bad-select variants).
// Latency: checks out_valid one cycle after accept.
// Backpressure: exercises stalled channels, broadcast all-or-nothing and bad-select accept.
module tb_demux_stream_1_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr_a = 1'b0;
    logic err_clr_b = 1'b0;
    logic [7:0] err_a;
    logic [7:0] err_b;
    logic [1:0] err_c;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    demux_stream_1_n_if #(.WIDTH(16), .NUM_OUT(8)) ia ();
    demux_stream_1_n_if #(.WIDTH(16), .NUM_OUT(6)) ib ();
    demux_stream_1_n_if #(.WIDTH(16), .NUM_OUT(6)) ic ();

    demux_stream_1_n #(.WIDTH(16), .NUM_OUT(8), .ERR_W(8)) u_a (
        .clk (clk), .rst_n (rst_n), .bus (ia), .err_cnt (err_a), .err_clr (err_clr_a)
    );
    demux_stream_1_n #(.WIDTH(16), .NUM_OUT(6), .ERR_W(8)) u_b (
        .clk (clk), .rst_n (rst_n), .bus (ib), .err_cnt (err_b), .err_clr (err_clr_b)
    );
    demux_stream_1_n #(.WIDTH(16), .NUM_OUT(6), .ERR_W(2)) u_c (
        .clk (clk), .rst_n (rst_n), .bus (ic), .err_cnt (err_c), .err_clr (err_clr_b)
    );

    // The 2-bit-counter instance sees exactly the same stimulus as the 6-channel one.
    assign ic.in_valid  = ib.in_valid;
    assign ic.in_data   = ib.in_data;
    assign ic.in_sel    = ib.in_sel;
    assign ic.in_bcast  = ib.in_bcast;
    assign ic.out_ready = ib.out_ready;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ia.in_valid = 1'b0; ia.in_data = '0; ia.in_sel = '0; ia.in_bcast = 1'b0; ia.out_ready = '0;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.in_sel = '0; ib.in_bcast = 1'b0; ib.out_ready = '0;

        // Reset state
        #3;
        chk("rst_valid", 128'(ia.out_valid), 128'h0);
        chk("rst_data",  ia.out_data, 128'h0);
        chk("rst_err",   128'(err_a), 128'h0);
        chk("rst_ready", 128'(ia.in_ready), 128'h1);
        #9 rst_n = 1'b1;
        tick();

        // Unicast to channel 3
        ia.out_ready = 8'hFF; ia.in_valid = 1'b1; ia.in_sel = 3'd3; ia.in_data = 16'hA5A5;
        #1 chk("uni_ready", 128'(ia.in_ready), 128'h1);
        tick();
        ia.in_valid = 1'b0;
        chk("uni_valid", 128'(ia.out_valid), 128'h08);
        chk("uni_data",  ia.out_data, 128'hA5A5 << 48);
        tick();
        chk("uni_drain_valid", 128'(ia.out_valid), 128'h0);
        chk("uni_drain_data",  ia.out_data, 128'h0);

        // Stall isolation: channel 2 full and stalled
        ia.out_ready = 8'h00; ia.in_valid = 1'b1; ia.in_sel = 3'd2; ia.in_data = 16'h2222;
        tick();
        ia.in_data = 16'hDEAD;
        #1 chk("stall_ready", 128'(ia.in_ready), 128'h0);
        tick();
        chk("stall_valid", 128'(ia.out_valid), 128'h04);
        chk("stall_hold",  128'(ia.out_data[2*16 +: 16]), 128'h2222);
        ia.in_sel = 3'd5; ia.in_data = 16'h5555;
        #1 chk("other_ready", 128'(ia.in_ready), 128'h1);
        tick();
        ia.in_valid = 1'b0;
        chk("other_valid", 128'(ia.out_valid), 128'h24);
        chk("other_data",  128'(ia.out_data[5*16 +: 16]), 128'h5555);
        chk("stall_hold2", 128'(ia.out_data[2*16 +: 16]), 128'h2222);
        ia.out_ready = 8'hFF;
        tick();
        chk("stall_drain", 128'(ia.out_valid), 128'h0);

        // Back-to-back on channel 1
        ia.in_valid = 1'b1; ia.in_sel = 3'd1;
        for (int i = 1; i <= 4; i++) begin
            ia.in_data = 16'(i);
            #1 chk($sformatf("b2b_ready%0d", i), 128'(ia.in_ready), 128'h1);
            tick();
            chk($sformatf("b2b_valid%0d", i), 128'(ia.out_valid), 128'h02);
            chk($sformatf("b2b_data%0d", i),  128'(ia.out_data[1*16 +: 16]), 128'(i));
        end
        ia.in_valid = 1'b0;
        tick();
        chk("b2b_drain", 128'(ia.out_valid), 128'h0);

        // Broadcast blocked by stalled channel 6
        ia.out_ready = 8'h00; ia.in_valid = 1'b1; ia.in_sel = 3'd6; ia.in_data = 16'h6666;
        tick();
        ia.in_bcast = 1'b1; ia.in_sel = 3'd0; ia.in_data = 16'h1234;
        #1 chk("bc_blocked", 128'(ia.in_ready), 128'h0);
        tick();
        chk("bc_no_partial", 128'(ia.out_valid), 128'h40);
        chk("bc_hold6", 128'(ia.out_data[6*16 +: 16]), 128'h6666);
        ia.out_ready = 8'h40;
        #1 chk("bc_ready", 128'(ia.in_ready), 128'h1);
        tick();
        ia.in_valid = 1'b0; ia.in_bcast = 1'b0;
        chk("bc_valid", 128'(ia.out_valid), 128'hFF);
        chk("bc_data",  ia.out_data, {8{16'h1234}});
        ia.out_ready = 8'hFF;
        tick();
        chk("bc_drain", 128'(ia.out_valid), 128'h0);
        chk("a_err_zero", 128'(err_a), 128'h0);

        // Bad select on the 6-channel instances
        ib.in_valid = 1'b1; ib.in_sel = 3'd7; ib.in_data = 16'hBAD0;
        #1 chk("bad_ready", 128'(ib.in_ready), 128'h1);
        tick(); tick(); tick();
        ib.in_valid = 1'b0;
        chk("bad_err3",   128'(err_b), 128'h3);
        chk("bad_valid",  128'(ib.out_valid), 128'h0);
        chk("bad_err3_c", 128'(err_c), 128'h3);
        ib.in_valid = 1'b1; err_clr_b = 1'b1;
        tick();
        err_clr_b = 1'b0;
        chk("clr_prio",   128'(err_b), 128'h0);
        chk("clr_prio_c", 128'(err_c), 128'h0);
        ib.in_sel = 3'd6;
        tick(); tick(); tick(); tick(); tick();
        ib.in_valid = 1'b0;
        chk("err5",     128'(err_b), 128'h5);
        chk("err_sat",  128'(err_c), 128'h3);
        chk("bad_valid2", 128'(ib.out_valid), 128'h0);

        // Async reset mid-stream with channels 0 and 4 full
        ia.out_ready = 8'h00; ia.in_valid = 1'b1; ia.in_sel = 3'd0; ia.in_data = 16'h0A0A;
        tick();
        ia.in_sel = 3'd4; ia.in_data = 16'h4444;
        tick();
        ia.in_valid = 1'b0;
        chk("pre_rst_valid", 128'(ia.out_valid), 128'h11);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(ia.out_valid), 128'h0);
        chk("arst_data",  ia.out_data, 128'h0);
        chk("arst_err",   128'(err_b), 128'h0);
        #2 rst_n = 1'b1;
        tick();
        ia.in_valid = 1'b1; ia.in_sel = 3'd4; ia.in_data = 16'hBEEF;
        #1 chk("post_rst_ready", 128'(ia.in_ready), 128'h1);
        tick();
        ia.in_valid = 1'b0;
        chk("post_rst_valid", 128'(ia.out_valid), 128'h10);
        chk("post_rst_data",  ia.out_data, 128'hBEEF << 64);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/demux_stream_1_n.md
Name: demux_stream_1_n

Overview:
- Parametrised, registered successor of the combinational 1-to-8 demux.
- Steers a WIDTH-bit word from one valid/ready input stream to one of NUM_OUT output streams, or to all of them in broadcast mode.
- Each output has a one-entry holding register, so a stalled channel does not block traffic bound for other channels.
- Sits between the datapath producer and per-unit consumers.

Parameters:
- WIDTH, 16, data word width.
- NUM_OUT, 8, output channel count; legal range 2..32, need not be a power of 2.
- SEL_W, $clog2(NUM_OUT), selector width; derived, must not be overridden.
- ERR_W, 8, width of the saturating bad-select counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle when in_valid && in_ready.
- in_data  in  WIDTH  input word.
- in_sel  in  SEL_W  destination channel; sampled with in_data.
- in_bcast  in  1  1 = deliver to every channel; in_sel is ignored.
- out_valid  out  NUM_OUT  per-channel valid.
- out_ready  in  NUM_OUT  per-channel consumer ready.
- out_data  out  NUM_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- err_cnt  out  ERR_W  count of accepted words with in_sel >= NUM_OUT.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async assert, sync release): all out_valid=0, all out_data=0, err_cnt=0. in_ready follows combinationally from the reset-state registers.
- Channel k is "free" when !out_valid[k] || out_ready[k] (empty, or draining this cycle).
- in_ready is combinational, with no dependence on in_valid:
  - unicast, in_sel < NUM_OUT: in_ready = free[in_sel].
  - unicast, in_sel >= NUM_OUT: in_ready = 1; the word is discarded.
  - broadcast: in_ready = AND of free[k] over all k. All-or-nothing; no partial delivery.
- Accept (in_valid && in_ready):
  - Target register(s) load in_data and set out_valid the next cycle. Latency is 1 cycle from accept to out_valid.
  - Discarded words increment err_cnt.
- Drain (out_valid[k] && out_ready[k] with no new load to k): out_valid[k] clears and out_data[k] returns to 0 next cycle. Data is zero whenever invalid.
- Simultaneous drain and load on the same channel: the new word replaces the old; out_valid stays 1. Full throughput is 1 word/cycle per channel.
- out_data[k] and out_valid[k] are held stable while out_valid[k] && !out_ready[k].
- err_cnt:
  - Saturates at all-ones.
  - err_clr has priority over an increment in the same cycle; the result is 0.
- Reset asserted mid-operation: held words are lost, outputs clear immediately, and the upstream must re-send.
- No internal FSM beyond per-channel valid flags. Each channel is a 2-state EMPTY/FULL machine:
  - EMPTY->FULL on load.
  - FULL->EMPTY on drain without load.
  - FULL->FULL on load, or on stall.

Decomposition:
- Shared package holds:
  - the channel index type.
  - the out_data slice helper function.
  - the default WIDTH and NUM_OUT constants shared with the mux counterpart.
- Sub-module demux_stream_slot holds one channel's register:
  - ports: clk, rst_n, load, load_data, out_ready, out_valid, out_data, free.
  - instantiated NUM_OUT times via generate.

Test Plan:
- Reset and unicast: reset, then in_valid=1, in_sel=3, in_data=16'hA5A5 with all out_ready=1. Next cycle out_valid=8'b0000_1000 and channel 3 data=16'hA5A5; all other channels' data=0.
- Stall isolation:
  - Channel 2 is full with out_ready[2]=0. Sending to channel 2 gives in_ready=0; the word is held, with no overwrite and stable data.
  - Sending in_sel=5 the same cycle is accepted, and channel 5 is valid next cycle.
- Back-to-back same channel: with out_ready[1]=1 constantly, stream 16'h0001..16'h0004 to channel 1. One word emerges per cycle, in order, with in_ready=1 throughout.
- Broadcast: in_bcast=1, in_data=16'h1234, with channel 6 stalled full. in_ready=0 until out_ready[6] rises. Then all 8 channels show 16'h1234 in the same cycle.
- Bad select: NUM_OUT=6, in_sel=7, three accepts. in_ready=1, no out_valid change, err_cnt=3. err_clr together with another bad accept gives err_cnt=0. With ERR_W=2 and 5 errors, err_cnt saturates at 3.
- Async reset mid-stream: assert rst_n=0 between clock edges while channels 0 and 4 are full. out_valid=0 and data=0 immediately; after release, the first new accept works normally.
